// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 chain controller.
package hc595_pkg;

    // Default chain geometry and shift rate.
    localparam int unsigned DefChainLen = 2;
    localparam int unsigned DefDiv      = 2;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StLatch = 2'd2
    } hc595_state_e;

endpackage : hc595_pkg

// File: rtl/hc595_bit_timer.sv
// Divider for one serial bit: 2*DIV cycles, low half then high half.
// It free-runs while enabled and is held at zero by clear_i.
module hc595_bit_timer #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic next_high_o,
    output logic half_end_o,
    output logic bit_end_o
);

    localparam int unsigned CntW = $clog2(2 * DIV);
    localparam logic [CntW-1:0] CntMax  = CntW'(2 * DIV - 1);
    localparam logic [CntW-1:0] HalfMax = CntW'(DIV - 1);
    localparam logic [CntW-1:0] HighVal = CntW'(DIV);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Next divider value: clear wins, otherwise count and wrap at 2*DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Divider register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Phase of the upcoming cycle lets the caller register shcp without lag.
    assign next_high_o = (cnt_d >= HighVal);
    assign half_end_o  = (cnt_q == HalfMax);
    assign bit_end_o   = (cnt_q == CntMax);

endmodule : hc595_bit_timer

// File: rtl/hc595_chain_ctrl.sv
// Serial driver for a daisy-chain of 74HC595s: accepts a parallel frame,
// shifts it out on ds/shcp and latches it with stcp. Outputs stay blanked
// (oe high) until the first complete frame has been latched.
module hc595_chain_ctrl
    import hc595_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DefChainLen,
    parameter int unsigned DIV       = DefDiv,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [8*CHAIN_LEN-1:0] data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   shcp,
    output logic                   stcp,
    output logic                   ds,
    output logic                   oe
);

    localparam int unsigned W    = 8 * CHAIN_LEN;
    localparam int unsigned BitW = $clog2(W);
    localparam logic [BitW-1:0] LastBit = BitW'(W - 1);

    hc595_state_e    state_q;
    logic [W-1:0]    shreg_q;
    logic [BitW-1:0] bit_cnt_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            shcp_q;
    logic            stcp_q;
    logic            ds_q;
    logic            oe_q;

    logic            next_high;
    logic            half_end;
    logic            bit_end;
    logic [W-1:0]    shreg_next;
    logic            in_first_bit;
    logic            next_first_bit;

    // Divider is parked at zero in idle so every frame starts on a clean phase.
    hc595_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .clear_i     (state_q == StIdle),
        .next_high_o (next_high),
        .half_end_o  (half_end),
        .bit_end_o   (bit_end)
    );

    // Bit order: the bit presented on ds is always at the shifting end of the register.
    always_comb begin
        shreg_next     = shreg_q;
        in_first_bit   = 1'b0;
        next_first_bit = 1'b0;
        if (MSB_FIRST) begin
            shreg_next     = {shreg_q[W-2:0], 1'b0};
            in_first_bit   = data_in[W-1];
            next_first_bit = shreg_q[W-2];
        end else begin
            shreg_next     = {1'b0, shreg_q[W-1:1]};
            in_first_bit   = data_in[0];
            next_first_bit = shreg_q[1];
        end
    end

    // Sequencer with registered outputs; each output is set to its value for the next cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            shcp_q    <= 1'b0;
            stcp_q    <= 1'b0;
            ds_q      <= 1'b0;
            oe_q      <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // ready_q is high throughout idle, so valid alone means accept.
                    if (data_valid) begin
                        state_q   <= StShift;
                        shreg_q   <= data_in;
                        bit_cnt_q <= '0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        shcp_q    <= 1'b0;
                        ds_q      <= in_first_bit;
                    end
                end
                StShift: begin
                    shcp_q <= next_high;
                    if (bit_end) begin
                        if (bit_cnt_q == LastBit) begin
                            // ds keeps the last bit through the latch pulse.
                            state_q <= StLatch;
                            shcp_q  <= 1'b0;
                            stcp_q  <= 1'b1;
                        end else begin
                            // New bit goes out together with shcp falling.
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                            shreg_q   <= shreg_next;
                            ds_q      <= next_first_bit;
                        end
                    end
                end
                StLatch: begin
                    if (half_end) begin
                        state_q <= StIdle;
                        stcp_q  <= 1'b0;
                        done_q  <= 1'b1;
                        oe_q    <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    shcp_q  <= 1'b0;
                    stcp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign shcp       = shcp_q;
    assign stcp       = stcp_q;
    assign ds         = ds_q;
    assign oe         = oe_q;

endmodule : hc595_chain_ctrl

// File: tb/tb_hc595_chain_ctrl.sv
// Directed bench for hc595_chain_ctrl: a 2x595 MSB-first DIV=2 instance and
// a 1x595 LSB-first DIV=1 instance share clock and reset.
module tb_hc595_chain_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;

    logic [15:0] data_a  = '0;
    logic        valid_a = 1'b0;
    logic        ready_a, busy_a, done_a, shcp_a, stcp_a, ds_a, oe_a;

    logic [7:0]  data_b  = '0;
    logic        valid_b = 1'b0;
    logic        ready_b, busy_b, done_b, shcp_b, stcp_b, ds_b, oe_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int c0       = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    hc595_chain_ctrl #(
        .CHAIN_LEN (2),
        .DIV       (2),
        .MSB_FIRST (1'b1)
    ) dut_a (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_in    (data_a),
        .data_valid (valid_a),
        .data_ready (ready_a),
        .busy       (busy_a),
        .done       (done_a),
        .shcp       (shcp_a),
        .stcp       (stcp_a),
        .ds         (ds_a),
        .oe         (oe_a)
    );

    hc595_chain_ctrl #(
        .CHAIN_LEN (1),
        .DIV       (1),
        .MSB_FIRST (1'b0)
    ) dut_b (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_in    (data_b),
        .data_valid (valid_b),
        .data_ready (ready_b),
        .busy       (busy_b),
        .done       (done_b),
        .shcp       (shcp_b),
        .stcp       (stcp_b),
        .ds         (ds_b),
        .oe         (oe_b)
    );

    // Line monitors: ds captured at every shcp rise, plus cumulative event counts.
    logic [15:0] cap_a = '0;
    logic [7:0]  cap_b = '0;
    logic        shcp_a_p = 1'b0, stcp_a_p = 1'b0, ds_a_p = 1'b0, shcp_b_p = 1'b0;
    int rises_a = 0, stcp_rises_a = 0, stcp_hi_a = 0, dones_a = 0, viol_a = 0;
    int stcp_rise_cyc_a = 0, done_cyc_a = 0, rises_b = 0;

    always @(negedge sys_clk) begin
        if (shcp_a && !shcp_a_p) begin
            cap_a   <= {cap_a[14:0], ds_a};
            rises_a <= rises_a + 1;
        end
        if (shcp_a && (ds_a != ds_a_p)) viol_a <= viol_a + 1;
        if (stcp_a && !stcp_a_p) begin
            stcp_rises_a    <= stcp_rises_a + 1;
            stcp_rise_cyc_a <= cyc;
        end
        if (stcp_a) stcp_hi_a <= stcp_hi_a + 1;
        if (done_a) begin
            dones_a    <= dones_a + 1;
            done_cyc_a <= cyc;
        end
        if (shcp_b && !shcp_b_p) begin
            cap_b   <= {cap_b[6:0], ds_b};
            rises_b <= rises_b + 1;
        end
        shcp_a_p <= shcp_a;
        stcp_a_p <= stcp_a;
        ds_a_p   <= ds_a;
        shcp_b_p <= shcp_b;
    end

    int b_rises, b_stcp, b_hi, b_dones, b_viol, b_rises_b, b_stcp_pre;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic snap();
        b_rises   = rises_a;
        b_stcp    = stcp_rises_a;
        b_hi      = stcp_hi_a;
        b_dones   = dones_a;
        b_viol    = viol_a;
        b_rises_b = rises_b;
    endtask

    // Offer one frame to instance A for exactly the accept cycle, then scramble data_in.
    task automatic start_a(input logic [15:0] d);
        data_a  = d;
        valid_a = 1'b1;
        c0      = cyc;
        tick();
        valid_a = 1'b0;
        data_a  = ~d;
    endtask

    task automatic start_b(input logic [7:0] d);
        data_b  = d;
        valid_b = 1'b1;
        c0      = cyc;
        tick();
        valid_b = 1'b0;
        data_b  = ~d;
    endtask

    task automatic check_reset_a(input string tag);
        check_eq({tag, "_oe"}, oe_a, 1'b1);
        check_eq({tag, "_shcp"}, shcp_a, 1'b0);
        check_eq({tag, "_stcp"}, stcp_a, 1'b0);
        check_eq({tag, "_ds"}, ds_a, 1'b0);
        check_eq({tag, "_ready"}, ready_a, 1'b1);
        check_eq({tag, "_busy"}, busy_a, 1'b0);
        check_eq({tag, "_done"}, done_a, 1'b0);
    endtask

    initial begin
        // Reset held three cycles.
        sys_rst = 1'b1;
        tick(); tick(); tick();
        check_reset_a("rst");
        check_eq("rst_b_oe", oe_b, 1'b1);
        check_eq("rst_b_ready", ready_b, 1'b1);
        sys_rst = 1'b0;
        tick(); tick();

        // Single frame A5C3, MSB first, DIV=2.
        snap();
        start_a(16'hA5C3);
        check_eq("a5_busy", busy_a, 1'b1);
        check_eq("a5_ready", ready_a, 1'b0);
        wait_to(c0 + 2);
        check_eq("a5_shcp_c2", shcp_a, 1'b0);
        wait_to(c0 + 3);
        check_eq("a5_shcp_c3", shcp_a, 1'b1);
        wait_to(c0 + 66);
        check_eq("a5_oe_c66", oe_a, 1'b1);
        check_eq("a5_stcp_c66", stcp_a, 1'b1);
        wait_to(c0 + 67);
        check_eq("a5_done_c67", done_a, 1'b1);
        check_eq("a5_oe_c67", oe_a, 1'b0);
        check_eq("a5_stcp_c67", stcp_a, 1'b0);
        check_eq("a5_ready_c67", ready_a, 1'b1);
        tick();
        check_eq("a5_done_c68", done_a, 1'b0);
        check_eq("a5_cap", cap_a, 16'hA5C3);
        check_eq("a5_rises", rises_a - b_rises, 16);
        check_eq("a5_stcp_rise_cyc", stcp_rise_cyc_a - c0, 65);
        check_eq("a5_stcp_hi", stcp_hi_a - b_hi, 2);
        check_eq("a5_dones", dones_a - b_dones, 1);
        check_eq("a5_done_cyc", done_cyc_a - c0, 67);
        check_eq("a5_setup", viol_a - b_viol, 0);

        // Instance B: LSB first, DIV=1, frame 01 -> ds high only on the first rise.
        snap();
        start_b(8'h01);
        check_eq("b01_shcp_c1", shcp_b, 1'b0);
        wait_to(c0 + 2);
        check_eq("b01_shcp_c2", shcp_b, 1'b1);
        check_eq("b01_ds_c2", ds_b, 1'b1);
        wait_to(c0 + 17);
        check_eq("b01_stcp_c17", stcp_b, 1'b1);
        check_eq("b01_oe_c17", oe_b, 1'b1);
        wait_to(c0 + 18);
        check_eq("b01_done_c18", done_b, 1'b1);
        check_eq("b01_stcp_c18", stcp_b, 1'b0);
        check_eq("b01_oe_c18", oe_b, 1'b0);
        tick();
        check_eq("b01_cap", cap_b, 8'h80);
        check_eq("b01_rises", rises_b - b_rises_b, 8);
        start_b(8'hB4);
        wait_to(c0 + 19);
        check_eq("bb4_cap", cap_b, 8'h2D);

        // Back-to-back: valid held high, second frame taken in the done cycle.
        snap();
        data_a  = 16'h1234;
        valid_a = 1'b1;
        c0      = cyc;
        tick();
        data_a  = 16'hFFFF;
        wait_to(c0 + 67);
        check_eq("b2b_ready_done", ready_a, 1'b1);
        check_eq("b2b_done", done_a, 1'b1);
        tick();
        valid_a = 1'b0;
        check_eq("b2b_busy_c68", busy_a, 1'b1);
        check_eq("b2b_cap1", cap_a, 16'h1234);
        wait_to(c0 + 135);
        check_eq("b2b_cap2", cap_a, 16'hFFFF);
        check_eq("b2b_rises", rises_a - b_rises, 32);
        check_eq("b2b_stcp_rises", stcp_rises_a - b_stcp, 2);
        check_eq("b2b_stcp_hi", stcp_hi_a - b_hi, 4);
        check_eq("b2b_stcp_rise2", stcp_rise_cyc_a - c0, 132);
        check_eq("b2b_dones", dones_a - b_dones, 2);
        check_eq("b2b_done_cyc2", done_cyc_a - c0, 134);
        check_eq("b2b_idle", busy_a, 1'b0);

        // Valid pulsed mid-shift with zero data is ignored.
        snap();
        start_a(16'h3C5A);
        wait_to(c0 + 10);
        data_a  = 16'h0000;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        wait_to(c0 + 70);
        check_eq("ign_cap", cap_a, 16'h3C5A);
        check_eq("ign_dones", dones_a - b_dones, 1);
        check_eq("ign_stcp_rises", stcp_rises_a - b_stcp, 1);
        check_eq("ign_busy", busy_a, 1'b0);
        check_eq("ign_oe", oe_a, 1'b0);

        // Reset during bit 7 aborts the frame and blanks until the next latch.
        b_stcp_pre = stcp_rises_a;
        start_a(16'h00FF);
        wait_to(c0 + 30);
        sys_rst = 1'b1;
        tick();
        check_reset_a("midrst");
        sys_rst = 1'b0;
        tick();
        start_a(16'h8001);
        wait_to(c0 + 66);
        check_eq("post_oe_c66", oe_a, 1'b1);
        wait_to(c0 + 67);
        check_eq("post_oe_c67", oe_a, 1'b0);
        check_eq("post_done_c67", done_a, 1'b1);
        tick();
        check_eq("post_cap", cap_a, 16'h8001);
        check_eq("post_stcp_rises", stcp_rises_a - b_stcp_pre, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_hc595_chain_ctrl
